mem_wb_stall_stage: RTL
=======================

# mem_wb_stall_stage

Parametrised successor to the fixed-width MemWB writeback stage. It accepts one retiring instruction per cycle through a valid/ready handshake and selects the writeback value (PC+2, PC+4, ALU result or load data). Unlike its predecessor, it aligns sub-word loads by byte offset, stalls upstream while a load response is outstanding, and flags misaligned or illegal loads. It registers the register-file write port and keeps a DEPTH-entry history of retired writes for forwarding to earlier stages.

## Interface
- XLEN, 32: data/PC width; multiple of 32.
- REGID_W, 8: register index width.
- DEPTH, 2: forwarding history entries; ≥1.
- Clock is `clk`; reset is synchronous, active-high, named `reset`.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  retiring instruction present
- in_ready  out  1  stage can accept; high only in IDLE and not in reset
- in_wb_op  in  Wb_pkg enum  WNONE/PC2/PC4/ALU/MEM
- in_funct3  in  3  load type (MEM only)
- in_rd  in  REGID_W  destination register
- in_pc  in  XLEN  instruction PC
- in_alu  in  XLEN  ALU result
- in_addr_lo  in  2  load byte offset
- mem_rsp_valid  in  1  load data valid this cycle
- mem_rsp_data  in  XLEN  aligned word containing the load
- regs_write_out  out  1  register write strobe (registered)
- regs_wr_id_out  out  REGID_W  write index (registered)
- regs_data_out  out  XLEN  write data (registered)
- bad_load_out  out  1  one-cycle pulse on a misaligned or illegal load
- hist_valid_out / hist_rd_out / hist_data_out  out  DEPTH×(1/REGID_W/XLEN)  forwarding history; entry 0 is newest

## Operation
- FSM states are IDLE and WAIT_MEM. In IDLE, an accept is `in_valid && in_ready`.
- Non-MEM accept: compute the result and register it next cycle. PC2 gives in_pc+2 and PC4 gives in_pc+4, both mod 2^XLEN. ALU gives in_alu. WNONE produces no write. The FSM stays in IDLE.
- MEM accept with mem_rsp_valid high in the same cycle completes immediately, with no WAIT. Otherwise latch funct3/rd/offset and go to WAIT_MEM; in_ready drops.
- In WAIT_MEM, mem_rsp_valid completes the load and returns the FSM to IDLE, with in_ready high the following cycle.
- Load extract: LB/LBU take byte [8*off+:8]. LH/LHU take halfword [8*off+:16] and require off∈{0,2}. LW requires off=0. LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
- Misaligned loads and funct3∈{3,6,7} produce no write and pulse bad_load_out for one cycle, aligned with where the write would have been.
- rd=0 suppresses regs_write_out. The history entry is still not recorded.
- mem_rsp_valid in IDLE without a same-cycle MEM accept is ignored.
- History: each completed write shifts the history, inserting {1,rd,data} at entry 0. The oldest entry drops. No shift occurs on cycles without a write.

## Timing
- Latency is 1 cycle from accept (non-MEM) or from the mem_rsp_valid cycle (MEM) to regs_write_out.
- regs_write_out is a single-cycle pulse. id/data hold their last value when the strobe is low.
- Throughput is 1/cycle for non-MEM and zero-wait loads. A load waiting N cycles blocks N cycles.
- Reset values: all outputs 0, all history entries invalid, FSM in IDLE, in_ready 0 during the reset cycle.
- Reset during WAIT_MEM drops the pending load: no write and no bad_load pulse. A response arriving the cycle after reset is ignored.
- Reset has priority over a same-cycle accept or response.

## Structure
- Wb_pkg (shared, existing) holds the wb_op enum.
- Add Load_pkg with LB=0, LH=1, LW=2, LBU=4, LHU=5 and a `load_ok(funct3, off)` function.
- Sub-module `load_align`: combinational extract plus extend, parametrised by XLEN. It is the only sub-module.
- The FSM, output register and history shift register stay in the top.

## Test plan
- ALU op, rd=5, alu=0x1234 → next cycle regs_write_out=1, id=5, data=0x1234; hist[0]={1,5,0x1234}.
- PC4 with pc=0xFFFFFFFE → data=0x00000002 (wrap).
- LB with off=3 and rsp=0x80FFFFFF given 3 cycles after accept → in_ready low for 3 cycles, then data=0xFFFFFF80. LBU with the same inputs → data=0x00000080.
- LH with off=1 → no write, bad_load_out pulses once. funct3=3 gives the same response.
- Back-to-back: ALU(rd1), zero-wait LW(rd2, rsp=0xDEADBEEF), ALU(rd0) → two writes on consecutive cycles; after them hist[0]=rd2/0xDEADBEEF and hist[1]=rd1; rd0 produces no write.
- Reset in WAIT_MEM with mem_rsp_valid the next cycle → no write, in_ready=1 after reset release, history all invalid.

Source files
------------

// File: rtl/load_pkg.sv
// Load_pkg: load funct3 encodings and the byte-offset legality check.
package Load_pkg;
  localparam logic [2:0] LB = 3'd0;
  localparam logic [2:0] LH = 3'd1;
  localparam logic [2:0] LW = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  function automatic logic load_ok(input logic [2:0] funct3, input logic [1:0] off);
    return (funct3 == LB || funct3 == LBU) ||
           ((funct3 == LH || funct3 == LHU) && !off[0]) ||
           (funct3 == LW && off == 2'd0);
  endfunction
endpackage

// File: rtl/wb_pkg.sv
// Wb_pkg: writeback source selection shared by the pipeline stages.
package Wb_pkg;
  typedef enum logic [2:0] {WNONE, PC2, PC4, ALU, MEM} wb_op_t;
endpackage

// File: rtl/mem_wb_stall_stage_load_align.sv
// load_align: picks the addressed byte/halfword/word out of a memory word and extends it.
module load_align import Load_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] value
);
  logic [31:0] sh;
  assign sh = data[31:0] >> {off, 3'b000};
  always_comb
    value = funct3 == LB  ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
            funct3 == LBU ? {{(XLEN-8){1'b0}}, sh[7:0]} :
            funct3 == LH  ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
            funct3 == LHU ? {{(XLEN-16){1'b0}}, sh[15:0]} :
                            {{(XLEN-32){sh[31]}}, sh};
endmodule

// File: rtl/mem_wb_stall_stage.sv
// mem_wb_stall_stage: writeback stage with load stall, sub-word alignment and forwarding history.
module mem_wb_stall_stage import Wb_pkg::*, Load_pkg::*; #(
  parameter int XLEN = 32,
  parameter int REGID_W = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  wb_op_t                         in_wb_op,
  input  logic [2:0]                     in_funct3,
  input  logic [REGID_W-1:0]             in_rd,
  input  logic [XLEN-1:0]                in_pc,
  input  logic [XLEN-1:0]                in_alu,
  input  logic [1:0]                     in_addr_lo,
  input  logic                           mem_rsp_valid,
  input  logic [XLEN-1:0]                mem_rsp_data,
  output logic                           regs_write_out,
  output logic [REGID_W-1:0]             regs_wr_id_out,
  output logic [XLEN-1:0]                regs_data_out,
  output logic                           bad_load_out,
  output logic [DEPTH-1:0]               hist_valid_out,
  output logic [DEPTH-1:0][REGID_W-1:0]  hist_rd_out,
  output logic [DEPTH-1:0][XLEN-1:0]     hist_data_out
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, next;
  logic [2:0] pend_f3, ld_f3;
  logic [REGID_W-1:0] pend_rd, wr_rd;
  logic [1:0] pend_off, ld_off;
  logic [XLEN-1:0] ld_val, wb_data;
  logic accept, is_mem, go_wait, done_wait, load_done, ok, nonmem, wr_en, bad_now;
  assign in_ready = state == IDLE && !reset;
  assign accept = in_valid && in_ready;
  assign is_mem = in_wb_op == MEM;
  assign go_wait = accept && is_mem && !mem_rsp_valid;
  assign done_wait = state == WAIT_MEM && mem_rsp_valid;
  assign load_done = (accept && is_mem && mem_rsp_valid) || done_wait;
  assign nonmem = accept && (in_wb_op == PC2 || in_wb_op == PC4 || in_wb_op == ALU);
  load_align #(.XLEN(XLEN)) u_align (
    .funct3(ld_f3),
    .off(ld_off),
    .data(mem_rsp_data),
    .value(ld_val)
  );
  always_comb begin
    next = go_wait ? WAIT_MEM : done_wait ? IDLE : state;
    ld_f3 = done_wait ? pend_f3 : in_funct3;
    ld_off = done_wait ? pend_off : in_addr_lo;
    wr_rd = done_wait ? pend_rd : in_rd;
    ok = load_ok(ld_f3, ld_off);
    bad_now = load_done && !ok;
    wr_en = (nonmem || (load_done && ok)) && wr_rd != '0;
    wb_data = load_done ? ld_val :
              in_wb_op == PC2 ? in_pc + XLEN'(2) :
              in_wb_op == PC4 ? in_pc + XLEN'(4) : in_alu;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend_f3 <= '0;
      pend_rd <= '0;
      pend_off <= '0;
      regs_write_out <= 1'b0;
      regs_wr_id_out <= '0;
      regs_data_out <= '0;
      bad_load_out <= 1'b0;
      hist_valid_out <= '0;
      hist_rd_out <= '0;
      hist_data_out <= '0;
    end else begin
      state <= next;
      regs_write_out <= wr_en;
      bad_load_out <= bad_now;
      if (go_wait) begin
        pend_f3 <= in_funct3;
        pend_rd <= in_rd;
        pend_off <= in_addr_lo;
      end
      if (wr_en) begin
        regs_wr_id_out <= wr_rd;
        regs_data_out <= wb_data;
        for (int i = DEPTH - 1; i > 0; i--) begin
          hist_valid_out[i] <= hist_valid_out[i-1];
          hist_rd_out[i] <= hist_rd_out[i-1];
          hist_data_out[i] <= hist_data_out[i-1];
        end
        hist_valid_out[0] <= 1'b1;
        hist_rd_out[0] <= wr_rd;
        hist_data_out[0] <= wb_data;
      end
    end
  end
endmodule
